// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 3-stage pipeline.
// Turns branch resolution, multi-cycle memory/UART accesses and loader halt
// requests into stall/flush controls; adds a memory-wait watchdog and a
// saturating memory-stall cycle counter.
module pipeline_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_taken,
   input  logic             mem_req_MW,
   input  logic             mem_ack,
   input  logic             halt_req,
   input  logic             err_clr,
   output logic             stall_F,
   output logic             stall_DE,
   output logic             stall_MW,
   output logic             flush_DE,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [2:0] S_RUN    = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_HALT   = 3'd2;
   localparam logic [2:0] S_ERROR  = 3'd3;
   localparam logic [2:0] S_RESUME = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_nx;
   logic [TO_W-1:0]  wait_cnt;
   logic [TO_W-1:0]  wait_nx;
   logic [CNT_W-1:0] cnt;
   logic             err_q;
   logic             mstall;
   logic             stall;
   logic             flush;
   logic             count_en;

   // Next-state, wait counter and combinational stall/flush decode
   always_comb begin
      mstall   = mem_req_MW & ~mem_ack;
      stall    = 1'b0;
      state_nx = state;
      wait_nx  = wait_cnt;
      case (state)
         S_RUN: begin
            stall = mstall;
            if (mstall) begin
               state_nx = S_WAIT;
               wait_nx  = TO_W'(1);
            end else if (halt_req) begin
               state_nx = S_HALT;
            end
         end
         S_WAIT: begin
            stall = ~mem_ack;
            if (mem_ack) begin
               state_nx = S_RUN;
            end else if (wait_cnt == TO_W'(TIMEOUT)) begin
               state_nx = S_ERROR;
            end else begin
               wait_nx = wait_cnt + TO_W'(1);
            end
         end
         S_HALT: begin
            stall = 1'b1;
            if (!halt_req) state_nx = S_RESUME;
         end
         S_ERROR: begin
            stall = 1'b1;
            if (err_clr) state_nx = S_RESUME;
         end
         S_RESUME: begin
            stall    = 1'b0;
            state_nx = S_RUN;
         end
         default: begin
            stall    = 1'b0;
            state_nx = S_RUN;
         end
      endcase
      // A branch held during a stall is flushed in the first unstalled cycle;
      // RESUME always discards the possibly stale fetched instruction.
      flush    = (state == S_RESUME) | (br_taken & ~stall);
      count_en = stall & ((state == S_RUN) | (state == S_WAIT));
   end

   // State, watchdog, sticky error and saturating stall counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_RUN;
         wait_cnt <= '0;
         cnt      <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         err_q    <= (state_nx == S_ERROR);
         if (count_en && (cnt != '1)) cnt <= cnt + CNT_W'(1);
      end
   end

   assign stall_F      = rst_n & stall;
   assign stall_DE     = rst_n & stall;
   assign stall_MW     = rst_n & stall;
   assign flush_DE     = rst_n & flush;
   assign halted       = rst_n & ((state == S_HALT) | (state == S_ERROR));
   assign mem_err      = rst_n & err_q;
   assign stall_cycles = rst_n ? cnt : '0;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed plus randomized checks of pipeline_ctrl against
// a behavioural model built from flags (in-access, halted, errored, resuming).
module tb_pipeline_ctrl;

   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic br_taken = 1'b0, mem_req_MW = 1'b0, mem_ack = 1'b0;
   logic halt_req = 1'b0, err_clr = 1'b0;
   logic stall_F, stall_DE, stall_MW, flush_DE, halted, mem_err;
   logic [31:0] stall_cycles;

   logic req2 = 1'b0, ack2 = 1'b0;
   logic s2_F, s2_DE, s2_MW, f2, h2, e2;
   logic [2:0] cyc2;

   int tests = 0;
   int fails = 0;

   // model
   bit      m_acc, m_halt, m_err, m_res;
   int      m_len;
   longint  m_cnt;

   pipeline_ctrl #(.TIMEOUT(TO), .TO_W(8), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .br_taken(br_taken), .mem_req_MW(mem_req_MW),
      .mem_ack(mem_ack), .halt_req(halt_req), .err_clr(err_clr),
      .stall_F(stall_F), .stall_DE(stall_DE), .stall_MW(stall_MW),
      .flush_DE(flush_DE), .halted(halted), .mem_err(mem_err),
      .stall_cycles(stall_cycles)
   );

   pipeline_ctrl #(.TIMEOUT(20), .TO_W(8), .CNT_W(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .br_taken(1'b0), .mem_req_MW(req2),
      .mem_ack(ack2), .halt_req(1'b0), .err_clr(1'b0),
      .stall_F(s2_F), .stall_DE(s2_DE), .stall_MW(s2_MW),
      .flush_DE(f2), .halted(h2), .mem_err(e2),
      .stall_cycles(cyc2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_halt = 0; m_err = 0; m_res = 0; m_len = 0; m_cnt = 0;
   endtask

   // One clock cycle: drive inputs, check outputs at negedge, advance model.
   task automatic step(input bit b, input bit rq, input bit ak, input bit h, input bit c);
      bit e_st, e_fl, e_hl, e_er, mst;
      longint e_cnt;
      br_taken = b; mem_req_MW = rq; mem_ack = ak; halt_req = h; err_clr = c;
      @(negedge clk);
      mst = rq & !ak;
      e_cnt = m_cnt;
      if (!rst_n) begin
         e_st = 0; e_fl = 0; e_hl = 0; e_er = 0; e_cnt = 0;
      end else if (m_res) begin
         e_st = 0; e_fl = 1; e_hl = 0; e_er = 0;
      end else if (m_err) begin
         e_st = 1; e_fl = 0; e_hl = 1; e_er = 1;
      end else if (m_halt) begin
         e_st = 1; e_fl = 0; e_hl = 1; e_er = 0;
      end else begin
         e_st = m_acc ? !ak : mst;
         e_fl = b & !e_st;
         e_hl = 0; e_er = 0;
      end
      chk("stall_F", 64'(stall_F), 64'(e_st));
      chk("stall_DE", 64'(stall_DE), 64'(e_st));
      chk("stall_MW", 64'(stall_MW), 64'(e_st));
      chk("flush_DE", 64'(flush_DE), 64'(e_fl));
      chk("halted", 64'(halted), 64'(e_hl));
      chk("mem_err", 64'(mem_err), 64'(e_er));
      chk("stall_cycles", 64'(stall_cycles), 64'(e_cnt));
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (m_res) begin
         m_res = 0;
      end else if (m_err) begin
         if (c) begin m_err = 0; m_res = 1; end
      end else if (m_halt) begin
         if (!h) begin m_halt = 0; m_res = 1; end
      end else begin
         if (e_st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         if (m_acc) begin
            if (ak) m_acc = 0;
            else begin
               m_len++;
               // error once TIMEOUT+1 consecutive cycles have stalled
               if (m_len > int'(TO)) begin m_acc = 0; m_err = 1; end
            end
         end else if (mst) begin
            m_acc = 1; m_len = 1;
         end else if (h) begin
            m_halt = 1;
         end
      end
      #1;
   endtask

   initial begin
      logic [31:0] base;
      model_reset();

      // reset hold with all inputs high
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1);
      rst_n = 1'b1;
      chk("rst_cnt", 64'(stall_cycles), 64'd0);
      step(0, 0, 0, 0, 0);

      // saturation on the 3-bit counter instance
      req2 = 1'b1; ack2 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step(0, 0, 0, 0, 0);
         chk("sat_cnt", 64'(cyc2), 64'((k < 7) ? k : 7));
      end
      chk("sat_no_err", 64'(e2), 64'd0);
      ack2 = 1'b1;
      step(0, 0, 0, 0, 0);
      req2 = 1'b0; ack2 = 1'b0;
      step(0, 0, 0, 0, 0);
      chk("sat_hold", 64'(cyc2), 64'd7);

      // 3-cycle load
      base = stall_cycles;
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("load_cnt", 64'(stall_cycles - base), 64'd2);
      chk("load_err", 64'(mem_err), 64'd0);
      step(0, 0, 0, 0, 0);

      // branch held through a 2-cycle memory stall
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);

      // timeout, error, clear, resume
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
      chk("to_err", 64'(mem_err), 64'd1);
      chk("to_halted", 64'(halted), 64'd1);
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // halt and resume
      step(1, 0, 0, 1, 0);
      for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // halt raised during a memory wait
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 1, 1, 0);
      chk("hw_not_halted", 64'(halted), 64'd0);
      step(0, 0, 0, 1, 0);
      chk("hw_halted", 64'(halted), 64'd1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // randomized traffic, with occasional resets
      for (int i = 0; i < 1500; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         step(($urandom_range(0, 2) == 0), ($urandom_range(0, 4) < 2),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0));
      end
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
